bitcount_arbiter: RTL and testbench

- Shares one bitcounter datapath between N_REQ requesters, each of which wants the number of ones in a DATA_W-bit operand.
- Round-robin arbitration; sequences the bitcounter's s/done handshake and returns the result to the granted requester.
- A watchdog flags a datapath that never asserts done.
- Sits between switch/KEY-driven request sources and the bitcounter instance in the lab top level.

---
 rtl/bitcount_pkg.sv | 13 +
 rtl/bitcount_arbiter_rr_arbiter.sv | 34 +++
 rtl/bitcount_arbiter.sv | 107 ++++++++++
 tb/tb_bitcount_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitcount_pkg.sv
// Shared types and constants for the bitcounter arbiter slice.
package bitcount_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESP} state_t;

    localparam int DEFAULT_TIMEOUT = 64;

    // Result width needed to hold a popcount of a data_w-bit operand.
    function automatic int res_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bitcount_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic [N_REQ-1:0]         onehot
);

    localparam int PTR_W = $clog2(N_REQ);

    always_comb begin
        int j;
        logic [PTR_W-1:0] jj;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        jj     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jj = PTR_W'(j);
            if (!found && req[jj]) begin
                found      = 1'b1;
                idx        = jj;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitcount_arbiter.sv
// Round-robin front end that time-shares one bitcounter between N_REQ requesters,
// sequencing its s/done handshake and guarding it with a watchdog.
module bitcount_arbiter
    import bitcount_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int RES_W   = res_width(DATA_W),
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]        rsp_result,
    output logic                    error,
    output logic [DATA_W-1:0]       bc_a,
    output logic                    bc_s,
    output logic                    bc_reset,
    input  logic [RES_W-1:0]        bc_result,
    input  logic                    bc_done
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [WD_W-1:0]  wdog;
    logic [RES_W-1:0] res_lat;

    logic             arb_found;
    logic [PTR_W-1:0] arb_idx;
    logic [N_REQ-1:0] arb_onehot;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .found  (arb_found),
        .idx    (arb_idx),
        .onehot (arb_onehot)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wdog       <= '0;
            res_lat    <= '0;
            grant      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            error      <= 1'b0;
            bc_a       <= '0;
            bc_s       <= 1'b0;
            bc_reset   <= 1'b1;
        end else begin
            bc_reset  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (arb_found) begin
                    owner  <= arb_idx;
                    grant  <= arb_onehot;
                    bc_a   <= req_data[arb_idx*DATA_W +: DATA_W];
                    // Winner drops to lowest priority for the next round.
                    rr_ptr <= (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state  <= LOAD;
                end
                LOAD: begin
                    wdog  <= '0;
                    bc_s  <= 1'b1;
                    state <= RUN;
                end
                RUN: if (bc_done) begin
                    res_lat <= bc_result;
                    bc_s    <= 1'b0;
                    state   <= DRAIN;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    // Datapath hung: kick it and answer the owner with zero.
                    error      <= 1'b1;
                    bc_reset   <= 1'b1;
                    bc_s       <= 1'b0;
                    rsp_valid  <= N_REQ'(1) << owner;
                    rsp_result <= '0;
                    state      <= RESP;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                DRAIN: if (!bc_done) begin
                    rsp_valid  <= N_REQ'(1) << owner;
                    rsp_result <= res_lat;
                    state      <= RESP;
                end
                RESP: begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcount_arbiter.sv
// Directed bench for bitcount_arbiter with a behavioural bitcounter stand-in.
module tb_bitcount_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    grant, rsp_valid;
    logic [RW-1:0]   rsp_result;
    logic            error;
    logic [DW-1:0]   bc_a;
    logic            bc_s, bc_reset;
    logic [RW-1:0]   bc_result = '0;
    logic            bc_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit hang = 1'b0;
    int m_cnt = 0;

    always #5 clock = ~clock;

    bitcount_arbiter #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .error(error),
        .bc_a(bc_a), .bc_s(bc_s), .bc_reset(bc_reset),
        .bc_result(bc_result), .bc_done(bc_done)
    );

    // Bitcounter stand-in: done a few cycles after s, held while s, cleared when s drops.
    always @(posedge clock or negedge reset) begin
        if (!reset || bc_reset) begin
            bc_done <= 1'b0;
            m_cnt   <= 0;
        end else if (bc_s) begin
            if (!bc_done && !hang) begin
                if (m_cnt == 2) begin
                    bc_done   <= 1'b1;
                    bc_result <= RW'($countones(bc_a));
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else begin
            bc_done <= 1'b0;
            m_cnt   <= 0;
        end
    end

    typedef struct {
        bit            rst;
        logic [N-1:0]  set;
        logic [N*DW-1:0] data;
        int            idx;
        logic [RW-1:0] res;
        logic [DW-1:0] bca;
        logic [N-1:0]  drop;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event never seen, want it within bound", name);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (grant != '0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("grant_timeout");
    endtask

    task automatic wait_rsp(output bit ok, output int runs);
        ok = 1'b0;
        runs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (rsp_valid != '0) begin ok = 1'b1; break; end
            if (bc_s) runs++;
        end
        if (!ok) timeout_fail("rsp_timeout");
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bc_s) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("run_timeout");
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_bc_s", bc_s, 0);
        chk("rst_bc_reset", bc_reset, 1);
        chk("rst_error", error, 0);
        chk("rst_bc_a", bc_a, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_release_bc_reset", bc_reset, 0);
    endtask

    task automatic do_txn(input string tag, input int idx, input logic [RW-1:0] res,
                          input logic [DW-1:0] bca, input logic [N-1:0] drop);
        bit ok;
        int runs;
        wait_grant(ok);
        if (ok) begin
            chk({tag, "_grant"}, grant, 1 << idx);
            chk({tag, "_bc_a"}, bc_a, bca);
        end
        wait_rsp(ok, runs);
        if (ok) begin
            chk({tag, "_rsp_valid"}, rsp_valid, 1 << idx);
            chk({tag, "_rsp_result"}, rsp_result, res);
            chk({tag, "_grant_held"}, grant, 1 << idx);
        end
        @(posedge clock);
        #1;
        req = req & ~drop;
        chk({tag, "_idle_grant"}, grant, 0);
        chk({tag, "_idle_rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench stalled");
        $fatal(1);
    end

    initial begin
        bit ok;
        int runs;
        int pulses;
        int late_grant;
        logic [RW-1:0] seen_res;

        //            rst set      data           idx res   bca    drop
        vecs[0]  = '{1, 4'b0001, 32'h000000B5, 0, 4'd5, 8'hB5, 4'b0001};
        vecs[1]  = '{1, 4'b1111, 32'h810FFF00, 0, 4'd0, 8'h00, 4'b0000};
        vecs[2]  = '{0, 4'b1111, 32'h810FFF00, 1, 4'd8, 8'hFF, 4'b0000};
        vecs[3]  = '{0, 4'b1111, 32'h810FFF00, 2, 4'd4, 8'h0F, 4'b0000};
        vecs[4]  = '{0, 4'b1111, 32'h810FFF00, 3, 4'd2, 8'h81, 4'b0000};
        vecs[5]  = '{0, 4'b1111, 32'h810FFF00, 0, 4'd0, 8'h00, 4'b1111};
        vecs[6]  = '{1, 4'b0101, 32'h00700003, 0, 4'd2, 8'h03, 4'b0000};
        vecs[7]  = '{0, 4'b0101, 32'h00700003, 2, 4'd3, 8'h70, 4'b0000};
        vecs[8]  = '{0, 4'b0101, 32'h00700003, 0, 4'd2, 8'h03, 4'b0000};
        vecs[9]  = '{0, 4'b0101, 32'h00700003, 2, 4'd3, 8'h70, 4'b0000};
        vecs[10] = '{0, 4'b0101, 32'h00700003, 0, 4'd2, 8'h03, 4'b0000};
        vecs[11] = '{0, 4'b0101, 32'h00700003, 2, 4'd3, 8'h70, 4'b0101};

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            req_data = vecs[k].data;
            req      = req | vecs[k].set;
            do_txn($sformatf("v%0d", k), vecs[k].idx, vecs[k].res, vecs[k].bca, vecs[k].drop);
        end

        // Watchdog: last winner was 2, so requester 1 is found by wrapping.
        hang = 1'b1;
        req_data[15:8] = 8'hAA;
        req = 4'b0010;
        wait_grant(ok);
        if (ok) chk("wd_grant", grant, 4'b0010);
        wait_rsp(ok, runs);
        if (ok) begin
            chk("wd_run_cycles", runs, 64);
            chk("wd_rsp_valid", rsp_valid, 4'b0010);
            chk("wd_rsp_result", rsp_result, 0);
            chk("wd_error", error, 1);
            chk("wd_bc_reset_high", bc_reset, 1);
        end
        @(posedge clock);
        #1;
        req = '0;
        chk("wd_bc_reset_pulse", bc_reset, 0);
        chk("wd_error_sticky", error, 1);
        hang = 1'b0;
        req_data[7:0] = 8'hB5;
        req = 4'b0001;
        do_txn("wd_next", 0, 4'd5, 8'hB5, 4'b0001);
        chk("wd_error_after", error, 1);

        // Reset mid-RUN, then requesters 2 and 3 pending: pointer must restart at 0.
        hang = 1'b1;
        req_data[23:16] = 8'hFF;
        req_data[31:24] = 8'h01;
        req = 4'b0100;
        wait_grant(ok);
        if (ok) chk("mr_grant", grant, 4'b0100);
        wait_run(ok);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mr_grant_cleared", grant, 0);
        chk("mr_bc_s_cleared", bc_s, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_bc_reset", bc_reset, 1);
        chk("mr_error_cleared", error, 0);
        req = 4'b1100;
        hang = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        do_txn("mr_rerun", 2, 4'd8, 8'hFF, 4'b0100);
        do_txn("mr_next", 3, 4'd1, 8'h01, 4'b1000);

        // Requester 1 drops req while its transaction is running.
        req_data[15:8] = 8'h07;
        req = 4'b0010;
        wait_grant(ok);
        if (ok) chk("dr_grant", grant, 4'b0010);
        wait_run(ok);
        req[1] = 1'b0;
        pulses = 0;
        late_grant = 0;
        seen_res = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rsp_valid[1]) begin
                pulses++;
                seen_res = rsp_result;
            end else if (pulses > 0 && grant[1]) begin
                late_grant++;
            end
        end
        chk("dr_rsp_pulses", pulses, 1);
        chk("dr_rsp_result", seen_res, 3);
        chk("dr_late_grant", late_grant, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
